// File: rtl/rr_cs_scheduler_8.sv
// Round-robin scheduler sharing one 8-way active-low select among 8 requesters.
// Each grant is bounded to MAX_HOLD cycles. After every grant, all selects stay
// high for GAP_CYCLES cycles, so two selects can never overlap.
// All outputs are registered.
module rr_cs_scheduler_8 #(
    parameter int MAX_HOLD   = 4,   // 1..15
    parameter int GAP_CYCLES = 1    // 1..7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en_n,
    input  logic [7:0] req,
    output logic [7:0] cs_n,
    output logic       grant_valid,
    output logic [2:0] grant_idx
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GAP
    } state_t;

    state_t     state_reg;
    logic [7:0] cs_n_reg;
    logic       grant_valid_reg;
    logic [2:0] grant_idx_reg;
    logic [2:0] ptr_reg;
    logic [3:0] hold_cnt_reg;
    logic [2:0] gap_cnt_reg;

    // Request vector rotated so that bit 0 is the first candidate after ptr.
    logic [7:0] rot_req;
    logic       win_valid;
    logic [2:0] win_off;
    logic [2:0] win_idx;
    logic [7:0] win_cs_n;

    // The 3-bit index arithmetic wraps 7 -> 0 on its own.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_rot
            assign rot_req[gi] = req[ptr_reg + 3'(gi + 1)];
        end
    endgenerate

    // Find the lowest set bit of the rotated vector, which is the first requester after ptr.
    always_comb begin
        win_valid = 1'b0;
        win_off   = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (rot_req[i]) begin
                win_valid = 1'b1;
                win_off   = 3'(i);
            end
        end
    end

    assign win_idx = ptr_reg + win_off + 3'd1;

    // Active-low one-hot decode of the winner, matching the 3-to-8 decoder convention.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_dec
            assign win_cs_n[gi] = (win_idx != 3'(gi));
        end
    endgenerate

    // Scheduler FSM with registered outputs. Reset wins over enable, and enable wins over the state transitions.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            cs_n_reg        <= 8'hFF;
            grant_valid_reg <= 1'b0;
            grant_idx_reg   <= 3'd0;
            ptr_reg         <= 3'd7;
            hold_cnt_reg    <= 4'd0;
            gap_cnt_reg     <= 3'd0;
        end else if (en_n) begin
            state_reg       <= ST_IDLE;
            cs_n_reg        <= 8'hFF;
            grant_valid_reg <= 1'b0;
            hold_cnt_reg    <= 4'd0;
            gap_cnt_reg     <= 3'd0;
            // An aborted grant still counts as served for the fairness order.
            if (state_reg == ST_GRANT) begin
                ptr_reg <= grant_idx_reg;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (win_valid) begin
                        state_reg       <= ST_GRANT;
                        cs_n_reg        <= win_cs_n;
                        grant_valid_reg <= 1'b1;
                        grant_idx_reg   <= win_idx;
                        hold_cnt_reg    <= 4'd1;
                    end
                end
                ST_GRANT: begin
                    if (!req[grant_idx_reg] || (hold_cnt_reg == 4'(MAX_HOLD))) begin
                        state_reg       <= ST_GAP;
                        cs_n_reg        <= 8'hFF;
                        grant_valid_reg <= 1'b0;
                        ptr_reg         <= grant_idx_reg;
                        hold_cnt_reg    <= 4'd0;
                        gap_cnt_reg     <= 3'd1;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg + 4'd1;
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg < 3'(GAP_CYCLES)) begin
                        gap_cnt_reg <= gap_cnt_reg + 3'd1;
                    end else begin
                        gap_cnt_reg <= 3'd0;
                        if (win_valid) begin
                            state_reg       <= ST_GRANT;
                            cs_n_reg        <= win_cs_n;
                            grant_valid_reg <= 1'b1;
                            grant_idx_reg   <= win_idx;
                            hold_cnt_reg    <= 4'd1;
                        end else begin
                            state_reg <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_reg       <= ST_IDLE;
                    cs_n_reg        <= 8'hFF;
                    grant_valid_reg <= 1'b0;
                    hold_cnt_reg    <= 4'd0;
                    gap_cnt_reg     <= 3'd0;
                end
            endcase
        end
    end

    assign cs_n        = cs_n_reg;
    assign grant_valid = grant_valid_reg;
    assign grant_idx   = grant_idx_reg;

endmodule

// File: tb/tb_rr_cs_scheduler_8.sv
// Self-checking bench for rr_cs_scheduler_8.
// It runs a sequence of directed scenarios, then a randomized phase.
// Both are checked every cycle against a behavioural model of owner, hold and gap bookkeeping.
module tb_rr_cs_scheduler_8;

    localparam int MAX_HOLD   = 4;
    localparam int GAP_CYCLES = 1;

    logic       clk;
    logic       rst_n;
    logic       en_n;
    logic [7:0] req;
    logic [7:0] cs_n;
    logic       grant_valid;
    logic [2:0] grant_idx;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Model state: owner is -1 when nothing is granted.
    int m_owner = -1;
    int m_held  = 0;
    int m_gap   = 0;
    int m_last  = 7;
    int m_idx   = 0;

    rr_cs_scheduler_8 #(
        .MAX_HOLD   (MAX_HOLD),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_n        (en_n),
        .req         (req),
        .cs_n        (cs_n),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Next owner in round-robin order: the first requester strictly after last, wrapping round to last itself.
    function automatic int pick(input int last, input logic [7:0] r);
        int w;
        w = -1;
        for (int k = 1; k <= 8; k++) begin
            if (r[(last + k) % 8]) begin
                w = (last + k) % 8;
                break;
            end
        end
        return w;
    endfunction

    task automatic model_step(input logic rn, input logic en, input logic [7:0] r);
        int w;
        if (!rn) begin
            m_owner = -1; m_held = 0; m_gap = 0; m_last = 7; m_idx = 0;
        end else if (en) begin
            if (m_owner >= 0) m_last = m_owner;
            m_owner = -1; m_held = 0; m_gap = 0;
        end else if (m_owner >= 0) begin
            if (!r[m_owner] || m_held == MAX_HOLD) begin
                m_last  = m_owner;
                m_owner = -1;
                m_held  = 0;
                m_gap   = GAP_CYCLES;
            end else begin
                m_held++;
            end
        end else if (m_gap > 1) begin
            m_gap--;
        end else begin
            m_gap = 0;
            w = pick(m_last, r);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 1;
                m_idx   = w;
            end
        end
    endtask

    // One clock: apply inputs, advance the model at the edge, then check every output 1 ns later.
    task automatic cycle(input logic rn, input logic en, input logic [7:0] r);
        logic [7:0] exp_cs;
        rst_n = rn; en_n = en; req = r;
        @(posedge clk);
        model_step(rn, en, r);
        #1;
        cyc++;
        exp_cs = (m_owner >= 0) ? ~(8'd1 << m_owner) : 8'hFF;
        $display("cyc %0d rst_n=%b en_n=%b req=%02h -> cs_n=%02h gv=%b idx=%0d", cyc, rn, en, r, cs_n, grant_valid, grant_idx);
        chk("cs_n", 32'(cs_n), 32'(exp_cs));
        chk("grant_valid", 32'(grant_valid), 32'(m_owner >= 0));
        chk("grant_idx", 32'(grant_idx), 32'(m_idx));
        chk("onehot", 32'($countones(~cs_n) <= 1), 32'd1);
        chk("gv_consistent", 32'(grant_valid), 32'(cs_n != 8'hFF));
    endtask

    initial begin
        logic [7:0] exp_seq [11];
        logic [7:0] rr;
        logic       ee;
        logic       rs;
        rst_n = 1'b0; en_n = 1'b0; req = 8'h00;

        // Reset, then idle for 10 cycles.
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 8'h00);
            chk("idle_cs_n", 32'(cs_n), 32'hFF);
            chk("idle_idx", 32'(grant_idx), 32'd0);
        end

        // A single short request to index 3.
        cycle(1'b1, 1'b0, 8'h08);
        chk("short_cs1", 32'(cs_n), 32'hF7);
        chk("short_idx", 32'(grant_idx), 32'd3);
        cycle(1'b1, 1'b0, 8'h08);
        chk("short_cs2", 32'(cs_n), 32'hF7);
        cycle(1'b1, 1'b0, 8'h00);
        chk("short_gap", 32'(cs_n), 32'hFF);
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h00);

        // Fairness between indices 0 and 7. A reset first puts ptr back to 7.
        cycle(1'b0, 1'b0, 8'h00);
        exp_seq = '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF,
                    8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'hFF, 8'hFE};
        for (int i = 0; i < 11; i++) begin
            cycle(1'b1, 1'b0, 8'h81);
            chk("rr_seq", 32'(cs_n), 32'(exp_seq[i]));
        end
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'h00);

        // Wrap: once index 6 has been served, index 0 wins next.
        cycle(1'b1, 1'b0, 8'h40);
        chk("wrap_g6", 32'(grant_idx), 32'd6);
        cycle(1'b1, 1'b0, 8'h40);
        cycle(1'b1, 1'b0, 8'h00);
        cycle(1'b1, 1'b0, 8'h41);
        chk("wrap_idx", 32'(grant_idx), 32'd0);
        chk("wrap_cs", 32'(cs_n), 32'hFE);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00);

        // en_n abort during the second cycle of a grant to index 5.
        cycle(1'b1, 1'b0, 8'h20);
        chk("abort_g5", 32'(cs_n), 32'hDF);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1, 8'h20);
            chk("abort_cs", 32'(cs_n), 32'hFF);
            chk("abort_idx", 32'(grant_idx), 32'd5);
        end
        cycle(1'b1, 1'b0, 8'h21);
        chk("after_abort_idx", 32'(grant_idx), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00);

        // Reset in the middle of a grant to index 4.
        cycle(1'b1, 1'b0, 8'h10);
        chk("mid_cs", 32'(cs_n), 32'hEF);
        cycle(1'b0, 1'b0, 8'h10);
        chk("mid_rst_cs", 32'(cs_n), 32'hFF);
        cycle(1'b1, 1'b0, 8'hFF);
        chk("mid_rst_first", 32'(grant_idx), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 8'h00);

        // Random phase: requests that persist for a while, occasional disable, rare reset.
        rr = 8'h00;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(3, 0) == 0) rr = 8'($urandom) & 8'($urandom);
            ee = ($urandom_range(15, 0) == 0);
            rs = ($urandom_range(63, 0) != 0);
            cycle(rs, ee, rr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
